game_level_ctrl: RTL
====================

Name: game_level_ctrl

Overview:
Top-level game sequencer for the bubble subsystem. It resets and starts the bubble array for each level and freezes motion between phases. It tracks level number and player lives, and consumes the array's win flag and the player/bubble collision flag. It sits between the keypad/collision logic and the bubble array, and drives the screen-overlay mux.

Parameters:
NUM_LEVELS, 3, number of levels; must be 1..4.
START_LIVES, 3, lives at game start; must be 1..3.
READY_FRAMES, 60, frames of frozen "get ready" before play; must be 1..255.
END_FRAMES, 90, frames of frozen pause after a level ends or a life is lost; must be 1..255.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per video frame
startKey  in  1  start button level; edge-detected internally
levelWin  in  1  bubble array reports all bubbles destroyed (level signal)
playerHit  in  1  player/bubble collision (level signal)
bubblesResetN  out  1  active-low one-clk pulse to the bubble array reset
bubblesStart  out  1  one-clk start pulse to the bubble array
freeze  out  1  high = player, arrow and bubble motion suspended
level  out  2  current level index, 0-based
lives  out  2  remaining lives
gameState  out  3  encoded state, for the overlay mux
gameOver  out  1  high in GAME_OVER
gameWon  out  1  high in VICTORY

Behaviour:
- Clock and reset: one clock, clk. Reset is resetN, asynchronous and active-low; all flops clear on resetN low.
- Reset values:
  - state IDLE, level 0, lives START_LIVES, frameCnt 0.
  - bubblesResetN 1, bubblesStart 0, freeze 1.
  - gameOver 0, gameWon 0, startKey history 0.
- Start-key edge: startRise = startKey & ~startKey_d (registered previous value). A held key produces exactly one event.
- Frame counter:
  - 8-bit frameCnt increments on startOfFrame only in READY, LIFE_LOST and LEVEL_DONE.
  - It clears to 0 on every state change.
  - "Count reached N" means frameCnt == N-1 while startOfFrame is high; the transition occurs on that clock.
- States, encoded as gameState: IDLE=0, READY=1, PLAY=2, LIFE_LOST=3, LEVEL_DONE=4, GAME_OVER=5, VICTORY=6.
  - IDLE: freeze=1. On startRise: level<=0, lives<=START_LIVES, pulse bubblesResetN low for 1 clk, go to READY.
  - READY: freeze=1. After READY_FRAMES frames, go to PLAY and assert bubblesStart for exactly 1 clk on that same transition clock.
  - PLAY: freeze=0.
    - levelWin=1 -> LEVEL_DONE.
    - Otherwise playerHit=1: if lives==1 go to GAME_OVER with lives<=0; else lives<=lives-1 and go to LIFE_LOST.
    - levelWin and playerHit high in the same cycle: levelWin wins; no life is lost.
  - LIFE_LOST: freeze=1. After END_FRAMES frames, pulse bubblesResetN and go to READY; level is unchanged, so the same level restarts.
  - LEVEL_DONE: freeze=1. After END_FRAMES frames:
    - if level==NUM_LEVELS-1, go to VICTORY;
    - else level<=level+1, pulse bubblesResetN and go to READY.
  - GAME_OVER and VICTORY: freeze=1, gameOver or gameWon held high. startRise -> IDLE.
- Input qualification:
  - levelWin and playerHit are ignored outside PLAY. Both may stay high after leaving PLAY; this must not cause a second transition.
  - startRise outside IDLE, GAME_OVER and VICTORY is ignored.
- Pulse separation: bubblesResetN and bubblesStart are registered outputs and are never active in the same clk. The reset pulse always precedes the start pulse by at least READY_FRAMES frames.
- lives never underflows; level never exceeds NUM_LEVELS-1.
- Reset asserted mid-game: everything returns to the reset values immediately; no pulses are generated while resetN is low.

Decomposition:
- Shared package game_pkg holds:
  - the state enum game_state_t (3-bit, values above);
  - default constants for READY_FRAMES and END_FRAMES;
  - the gameState encoding, shared with the overlay mux.
- One natural sub-module: frame_timer. It holds the 8-bit frame counter with clear, enable and startOfFrame inputs, a terminal-count input and a done output. It is reusable by other timed screens.

Test Plan:
- Start sequence: reset, startKey high for 100 clk. Expect one bubblesResetN low pulse, READY; after 60 startOfFrame pulses, one bubblesStart pulse; gameState=2 and freeze=0.
- Life loss: in PLAY with lives=3, pulse playerHit. Expect lives=2, LIFE_LOST; after 90 frames, one bubblesResetN pulse, READY with level still 0; later PLAY again.
- Level progression: in PLAY at level 0, raise levelWin. Expect LEVEL_DONE and freeze=1; after 90 frames, level=1, bubblesResetN pulse, READY. With levelWin still high in READY, no further transition occurs.
- Victory and priority: at level 2 (NUM_LEVELS=3), raise levelWin and playerHit in the same clk. Expect LEVEL_DONE with lives unchanged; after 90 frames, VICTORY with gameWon=1 and no reset pulse.
- Game over and restart: with lives=1, pulse playerHit. Expect GAME_OVER, lives=0, gameOver=1. A startKey rise returns to IDLE; a second rise gives lives=3, level=0, READY.
- Async reset mid-PLAY: drop resetN between clock edges. Outputs reach reset values immediately, with no bubblesStart or bubblesResetN pulse; holding startKey high through reset release causes no start until a new rising edge.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the bubble-game sequencer and the screen-overlay mux:
//   - game_state_t : 3-bit game state; its encoding is the gameState value
//                    seen by the overlay mux
//   - default frame counts for the frozen "get ready" and end-of-phase screens
//   - is_timed()   : states in which the frame timer runs
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int unsigned GAME_STATE_W     = 3;
  localparam int unsigned READY_FRAMES_DEF = 60;
  localparam int unsigned END_FRAMES_DEF   = 90;

  typedef enum logic [GAME_STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_READY      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_LIFE_LOST  = 3'd3,
    ST_LEVEL_DONE = 3'd4,
    ST_GAME_OVER  = 3'd5,
    ST_VICTORY    = 3'd6
  } game_state_t;

  // Frozen screens that end after a fixed number of frames.
  function automatic logic is_timed(input game_state_t st);
    return (st == ST_READY) || (st == ST_LIFE_LOST) || (st == ST_LEVEL_DONE);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// 8-bit video-frame counter for timed screens.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (wins over counting)
//   en_i    : counting enabled
//   sof_i   : one-clk start-of-frame pulse
//   tc_i    : terminal count, i.e. number of frames minus one
//   done_o  : combinational; high on the clock that delivers the last frame
// ---------------------------------------------------------------------------
module frame_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       sof_i,
  input  logic [7:0] tc_i,
  output logic       done_o
);

  logic [7:0] cnt_q;

  // Frame counter: clear has priority, otherwise count enabled frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i && sof_i) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign done_o = en_i && sof_i && (cnt_q == tc_i);

endmodule

// File: rtl/game_level_ctrl.sv
// ---------------------------------------------------------------------------
// game_level_ctrl
// Top-level game sequencer for the bubble subsystem.
//   clk, resetN      : clock, asynchronous active-low reset
//   startOfFrame     : one-clk pulse per video frame
//   startKey         : start button level (edge-detected here)
//   levelWin         : bubble array reports all bubbles destroyed
//   playerHit        : player/bubble collision
//   bubblesResetN    : active-low one-clk reset pulse to the bubble array
//   bubblesStart     : one-clk start pulse to the bubble array
//   freeze           : motion suspended when high
//   level, lives     : current level (0-based) and remaining lives
//   gameState        : encoded state for the overlay mux
//   gameOver/gameWon : high in GAME_OVER / VICTORY
// All outputs are registered.
// ---------------------------------------------------------------------------
module game_level_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned READY_FRAMES = READY_FRAMES_DEF,
  parameter int unsigned END_FRAMES   = END_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    startKey,
  input  logic                    levelWin,
  input  logic                    playerHit,
  output logic                    bubblesResetN,
  output logic                    bubblesStart,
  output logic                    freeze,
  output logic [1:0]              level,
  output logic [1:0]              lives,
  output logic [GAME_STATE_W-1:0] gameState,
  output logic                    gameOver,
  output logic                    gameWon
);

  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] INIT_LIVES = 2'(START_LIVES);
  localparam logic [7:0] READY_TC   = 8'(READY_FRAMES - 1);
  localparam logic [7:0] END_TC     = 8'(END_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic        start_key_q;
  logic        armed_q;
  logic        start_rise_s;
  logic        rst_pulse_s;
  logic        start_pulse_s;
  logic        timer_done_s;
  logic [7:0]  timer_tc_s;
  logic        bub_rst_n_q, bub_start_q, freeze_q, game_over_q, game_won_q;

  // armed_q blocks a key that was already held when reset released: a start
  // needs the key to have been seen released at least once since reset.
  assign start_rise_s = startKey && !start_key_q && armed_q;
  assign timer_tc_s   = (state_q == ST_READY) ? READY_TC : END_TC;

  frame_timer u_frame_timer (
    .clk_i  (clk),
    .rst_ni (resetN),
    .clr_i  (state_d != state_q),
    .en_i   (is_timed(state_q)),
    .sof_i  (startOfFrame),
    .tc_i   (timer_tc_s),
    .done_o (timer_done_s)
  );

  // Next-state, level/lives update and pulse requests.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    rst_pulse_s   = 1'b0;
    start_pulse_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          level_d     = 2'd0;
          lives_d     = INIT_LIVES;
          rst_pulse_s = 1'b1;
          state_d     = ST_READY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READY: begin
        if (timer_done_s) begin
          start_pulse_s = 1'b1;
          state_d       = ST_PLAY;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_PLAY: begin
        // A win in the same clock as a hit takes precedence; no life is lost.
        if (levelWin) begin
          state_d = ST_LEVEL_DONE;
        end else if (playerHit) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_LIFE_LOST;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_LIFE_LOST: begin
        if (timer_done_s) begin
          rst_pulse_s = 1'b1;
          state_d     = ST_READY;
        end else begin
          state_d = ST_LIFE_LOST;
        end
      end
      ST_LEVEL_DONE: begin
        if (timer_done_s) begin
          if (level_q >= LAST_LEVEL) begin
            state_d = ST_VICTORY;
          end else begin
            level_d     = level_q + 2'd1;
            rst_pulse_s = 1'b1;
            state_d     = ST_READY;
          end
        end else begin
          state_d = ST_LEVEL_DONE;
        end
      end
      ST_GAME_OVER, ST_VICTORY: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, key history and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      level_q     <= 2'd0;
      lives_q     <= INIT_LIVES;
      start_key_q <= 1'b0;
      armed_q     <= 1'b0;
      bub_rst_n_q <= 1'b1;
      bub_start_q <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
      game_won_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      start_key_q <= startKey;
      armed_q     <= armed_q | ~startKey;
      bub_rst_n_q <= ~rst_pulse_s;
      bub_start_q <= start_pulse_s;
      freeze_q    <= (state_d != ST_PLAY);
      game_over_q <= (state_d == ST_GAME_OVER);
      game_won_q  <= (state_d == ST_VICTORY);
    end
  end

  assign bubblesResetN = bub_rst_n_q;
  assign bubblesStart  = bub_start_q;
  assign freeze        = freeze_q;
  assign level         = level_q;
  assign lives         = lives_q;
  assign gameState     = state_q;
  assign gameOver      = game_over_q;
  assign gameWon       = game_won_q;

endmodule
